// File: rtl/func_pkg.sv
// Shared types and helpers for the truth-table equivalence sweeper.
package func_pkg;

  localparam int unsigned MAX_N    = 10;
  localparam int unsigned MAX_TT_W = 1 << MAX_N;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SWEEP,
    DONE
  } state_e;

  // Number of set bits among the low w entries of a truth table.
  function automatic int unsigned tt_popcount(input logic [MAX_TT_W-1:0] tt,
                                              input int unsigned w);
    int unsigned c = 0;
    for (int unsigned i = 0; i < w && i < MAX_TT_W; i++) begin
      if (tt[10'(i)]) c++;
    end
    return c;
  endfunction

endpackage

// File: rtl/func_lut.sv
// Truth-table lookup: f = tt[vec].
module func_lut #(
  parameter  int unsigned N    = 4,
  localparam int unsigned TT_W = 1 << N
) (
  input  logic [TT_W-1:0] tt,
  input  logic [N-1:0]    vec,
  output logic            f
);

  assign f = tt[vec];

endmodule

// File: rtl/func_equiv_sweeper.sv
// Sweeps all input vectors of two programmable N-input functions and reports
// equivalence, first mismatching vector, mismatch count and ON-set size of A.
module func_equiv_sweeper
  import func_pkg::*;
#(
  parameter  int unsigned N    = 4,
  localparam int unsigned TT_W = 1 << N
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            stop_on_mismatch,
  input  logic [TT_W-1:0] tt_a,
  input  logic [TT_W-1:0] tt_b,
  output logic            busy,
  output logic            done,
  output logic            equal,
  output logic [N-1:0]    first_mismatch,
  output logic [N:0]      mismatch_count,
  output logic [N:0]      ones_a,
  output logic [N-1:0]    vec
);

  state_e          state_q, state_d;
  logic [TT_W-1:0] ta_q, ta_d, tb_q, tb_d;
  logic            stop_q, stop_d;
  logic            found_q, found_d;
  logic            busy_q, busy_d, done_q, done_d, equal_q, equal_d;
  logic [N-1:0]    first_q, first_d, vec_q, vec_d;
  logic [N:0]      mc_q, mc_d, ones_q, ones_d;
  logic            fa_c, fb_c, mm_c;

  func_lut #(.N(N)) u_lut_a (.tt(ta_q), .vec(vec_q), .f(fa_c));
  func_lut #(.N(N)) u_lut_b (.tt(tb_q), .vec(vec_q), .f(fb_c));

  assign mm_c = fa_c ^ fb_c;

  // Next-state and datapath updates.
  always_comb begin
    state_d = state_q;
    ta_d    = ta_q;
    tb_d    = tb_q;
    stop_d  = stop_q;
    found_d = found_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    equal_d = equal_q;
    first_d = first_q;
    vec_d   = vec_q;
    mc_d    = mc_q;
    ones_d  = ones_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD;
          stop_d  = stop_on_mismatch;
          busy_d  = 1'b1;
        end
      end
      LOAD: begin
        ta_d    = tt_a;
        tb_d    = tt_b;
        vec_d   = '0;
        mc_d    = '0;
        ones_d  = '0;
        first_d = '0;
        found_d = 1'b0;
        equal_d = 1'b0;
        state_d = SWEEP;
      end
      SWEEP: begin
        ones_d = ones_q + (N+1)'(fa_c);
        mc_d   = mc_q + (N+1)'(mm_c);
        if (mm_c && !found_q) begin
          first_d = vec_q;
          found_d = 1'b1;
        end
        // vec holds at the last evaluated vector; it never wraps.
        if ((vec_q == N'(TT_W - 1)) || (mm_c && stop_q)) begin
          state_d = DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          equal_d = (mc_d == '0);
        end else begin
          vec_d = vec_q + N'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ta_q    <= '0;
      tb_q    <= '0;
      stop_q  <= 1'b0;
      found_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      equal_q <= 1'b0;
      first_q <= '0;
      vec_q   <= '0;
      mc_q    <= '0;
      ones_q  <= '0;
    end else begin
      state_q <= state_d;
      ta_q    <= ta_d;
      tb_q    <= tb_d;
      stop_q  <= stop_d;
      found_q <= found_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      equal_q <= equal_d;
      first_q <= first_d;
      vec_q   <= vec_d;
      mc_q    <= mc_d;
      ones_q  <= ones_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign equal          = equal_q;
  assign first_mismatch = first_q;
  assign mismatch_count = mc_q;
  assign ones_a         = ones_q;
  assign vec            = vec_q;

endmodule

// File: tb/tb_func_equiv_sweeper.sv
// Randomised and directed bench for func_equiv_sweeper (N=4, plus N=1 and N=10 builds).
module tb_func_equiv_sweeper;
  import func_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stop_on_mismatch;
  logic [15:0] tt_a, tt_b;
  logic        busy, done, equal;
  logic [3:0]  first_mismatch, vec;
  logic [4:0]  mismatch_count, ones_a;

  logic        start1, busy1, done1, equal1;
  logic [1:0]  tt_a1, tt_b1, mc1, ones1;
  logic [0:0]  first1, vec1;

  logic           start10, busy10, done10, equal10;
  logic [1023:0]  tt_a10, tt_b10;
  logic [9:0]     first10, vec10;
  logic [10:0]    mc10, ones10;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  func_equiv_sweeper #(.N(4)) dut (
    .clk(clk), .reset(reset), .start(start), .stop_on_mismatch(stop_on_mismatch),
    .tt_a(tt_a), .tt_b(tt_b), .busy(busy), .done(done), .equal(equal),
    .first_mismatch(first_mismatch), .mismatch_count(mismatch_count),
    .ones_a(ones_a), .vec(vec));

  func_equiv_sweeper #(.N(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .stop_on_mismatch(1'b0),
    .tt_a(tt_a1), .tt_b(tt_b1), .busy(busy1), .done(done1), .equal(equal1),
    .first_mismatch(first1), .mismatch_count(mc1), .ones_a(ones1), .vec(vec1));

  func_equiv_sweeper #(.N(10)) dut10 (
    .clk(clk), .reset(reset), .start(start10), .stop_on_mismatch(1'b0),
    .tt_a(tt_a10), .tt_b(tt_b10), .busy(busy10), .done(done10), .equal(equal10),
    .first_mismatch(first10), .mismatch_count(mc10), .ones_a(ones10), .vec(vec10));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: evaluate at most `limit` vectors in order, honouring stop mode.
  task automatic model(input logic [15:0] ta, input logic [15:0] tb, input bit stop,
                       input int limit, output int ones, output int mc,
                       output int first, output int last);
    ones = 0; mc = 0; first = 0; last = 0;
    for (int k = 0; k < 16 && k < limit; k++) begin
      last = k;
      ones += int'(ta[4'(k)]);
      if (ta[4'(k)] != tb[4'(k)]) begin
        if (mc == 0) first = k;
        mc++;
        if (stop) break;
      end
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_equal"}, 32'(equal), 0);
    chk({tag, "_first"}, 32'(first_mismatch), 0);
    chk({tag, "_mc"},    32'(mismatch_count), 0);
    chk({tag, "_ones"},  32'(ones_a), 0);
    chk({tag, "_vec"},   32'(vec), 0);
  endtask

  // One sweep with per-cycle comparison; disturb changes tables/pulses start mid-sweep and in DONE.
  task automatic run_sweep(input logic [15:0] ta, input logic [15:0] tb,
                           input bit stop, input bit disturb);
    int eo, em, ef, ek, po, pm, pf, pk;
    model(ta, tb, stop, 16, eo, em, ef, ek);
    if (!stop && ek == 15) chk("popcount_ref", 32'(eo), tt_popcount(1024'(ta), 16));
    @(negedge clk);
    tt_a = ta; tt_b = tb; stop_on_mismatch = stop; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_e0", 32'(busy), 1);
    chk("done_e0", 32'(done), 0);
    for (int j = 1; j <= ek + 3; j++) begin
      @(posedge clk); #1;
      if (j <= ek + 1) begin
        model(ta, tb, stop, j - 1, po, pm, pf, pk);
        chk("sw_busy",  32'(busy), 1);
        chk("sw_done",  32'(done), 0);
        chk("sw_equal", 32'(equal), 0);
        chk("sw_vec",   32'(vec), j - 1);
        chk("sw_ones",  32'(ones_a), po);
        chk("sw_mc",    32'(mismatch_count), pm);
        chk("sw_first", 32'(first_mismatch), pf);
      end else if (j == ek + 2) begin
        chk("dn_busy",  32'(busy), 0);
        chk("dn_done",  32'(done), 1);
        chk("dn_equal", 32'(equal), 32'(em == 0));
        chk("dn_vec",   32'(vec), ek);
        chk("dn_ones",  32'(ones_a), eo);
        chk("dn_mc",    32'(mismatch_count), em);
        chk("dn_first", 32'(first_mismatch), ef);
      end else begin
        chk("id_busy",  32'(busy), 0);
        chk("id_done",  32'(done), 0);
        chk("id_equal", 32'(equal), 32'(em == 0));
        chk("id_ones",  32'(ones_a), eo);
        chk("id_mc",    32'(mismatch_count), em);
      end
      start = 1'b0;
      if (disturb && j == 3 && j < ek + 1) begin
        tt_a = ~ta; tt_b = ~tb; stop_on_mismatch = ~stop; start = 1'b1;
      end else if (disturb && j == ek + 2) begin
        start = 1'b1;
      end
    end
    start = 1'b0;
  endtask

  initial begin
    int e;
    logic [15:0] ra, rb;
    reset = 1'b1; start = 1'b0; stop_on_mismatch = 1'b0; tt_a = '0; tt_b = '0;
    start1 = 1'b0; tt_a1 = '0; tt_b1 = '0;
    start10 = 1'b0; tt_a10 = '0; tt_b10 = '0;
    #1;
    chk_all_zero("rst");
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("post_rst");

    run_sweep(16'hFFFE, 16'hFFFE, 1'b0, 1'b0);
    chk("t1_equal", 32'(equal), 1);
    chk("t1_mc",    32'(mismatch_count), 0);
    chk("t1_first", 32'(first_mismatch), 0);
    chk("t1_ones",  32'(ones_a), 15);

    run_sweep(16'hFFFE, 16'h7FFE, 1'b0, 1'b0);
    chk("t2_equal", 32'(equal), 0);
    chk("t2_first", 32'(first_mismatch), 15);
    chk("t2_mc",    32'(mismatch_count), 1);
    chk("t2_ones",  32'(ones_a), 15);

    run_sweep(16'hAAAA, 16'h5555, 1'b0, 1'b0);
    chk("t3_mc",    32'(mismatch_count), 16);
    chk("t3_first", 32'(first_mismatch), 0);
    chk("t3_ones",  32'(ones_a), 8);

    run_sweep(16'hAAAA, 16'h5555, 1'b1, 1'b0);
    chk("t4_mc",   32'(mismatch_count), 1);
    chk("t4_ones", 32'(ones_a), 0);
    chk("t4_vec",  32'(vec), 0);

    run_sweep(16'h1234, 16'h1274, 1'b0, 1'b1);
    chk("t5_first", 32'(first_mismatch), 6);
    chk("t5_mc",    32'(mismatch_count), 1);
    chk("t5_ones",  32'(ones_a), 5);

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      case ($urandom_range(0, 2))
        0: rb = ra;
        1: rb = ra ^ (16'h1 << $urandom_range(0, 15));
        default: rb = 16'($urandom);
      endcase
      run_sweep(ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Reset in the middle of a sweep.
    @(negedge clk);
    tt_a = 16'hFFFE; tt_b = 16'h7FFE; stop_on_mismatch = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("ab_vec7", 32'(vec), 7);
    reset = 1'b1;
    #1;
    chk_all_zero("ab_rst");
    @(posedge clk); #1;
    chk_all_zero("ab_rst_edge");
    @(negedge clk); reset = 1'b0;
    for (int j = 0; j < 20; j++) begin
      @(posedge clk); #1;
      chk("ab_no_done", 32'(done), 0);
      chk("ab_no_busy", 32'(busy), 0);
    end
    run_sweep(16'h0000, 16'h0000, 1'b0, 1'b0);
    chk("ab_equal", 32'(equal), 1);
    chk("ab_ones",  32'(ones_a), 0);

    // N=1 build.
    @(negedge clk);
    tt_a1 = 2'b11; tt_b1 = 2'b01; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    e = 0;
    for (int j = 1; j <= 20; j++) begin
      @(posedge clk); #1;
      if (done1) begin e = j; break; end
    end
    chk("n1_latency", e, 3);
    chk("n1_first",   32'(first1), 1);
    chk("n1_mc",      32'(mc1), 1);
    chk("n1_ones",    32'(ones1), 2);
    chk("n1_equal",   32'(equal1), 0);

    // N=10 build.
    @(negedge clk);
    tt_a10 = '1; tt_b10 = {1'b0, {1023{1'b1}}}; start10 = 1'b1;
    @(posedge clk); #1;
    start10 = 1'b0;
    e = 0;
    for (int j = 1; j <= 1100; j++) begin
      @(posedge clk); #1;
      if (done10) begin e = j; break; end
    end
    chk("n10_latency", e, 1025);
    chk("n10_first",   32'(first10), 1023);
    chk("n10_mc",      32'(mc10), 1);
    chk("n10_ones",    32'(ones10), 1024);
    chk("n10_equal",   32'(equal10), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/func_equiv_sweeper.md
Name: func_equiv_sweeper

Overview:
- Sequential, parametrised successor to the fixed 4-input sum-of-terms evaluators.
- Holds two N-input Boolean functions as programmable truth tables, A and B.
- On request, sweeps every input vector once, one vector per clock.
- Reports equivalence, the first mismatching vector, the mismatch count and the ON-set size of A. Used as the on-chip equivalence checker next to the hand-built function blocks.

Parameters:
- N, 4, number of function inputs. Legal range 1..10.
- TT_W, 2**N, truth-table width. Derived; not overridable.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  request a sweep; sampled only in IDLE.
- stop_on_mismatch  input  1  mode bit, captured at start. 1 means end the sweep at the first mismatch.
- tt_a  input  TT_W  truth table A; bit k is f_a(vector k). Captured in LOAD.
- tt_b  input  TT_W  truth table B, same encoding as tt_a.
- busy  output  1  high in LOAD and SWEEP.
- done  output  1  one-cycle pulse in DONE.
- equal  output  1  result: no mismatch found.
- first_mismatch  output  N  lowest mismatching vector; 0 when equal=1.
- mismatch_count  output  N+1  number of mismatching vectors evaluated.
- ones_a  output  N+1  number of evaluated vectors with f_a=1.
- vec  output  N  vector currently being evaluated (debug).

Behaviour:
- Reset (asynchronous, active-high):
  - State goes to IDLE.
  - All outputs and internal registers clear to 0, including equal.
  - Reset asserted mid-sweep aborts the sweep; no done pulse is produced.
- Vector encoding: vec[0]=x1, vec[1]=y1, vec[2]=x2, vec[3]=y2 for N=4. Generally vec[i] is input i. f(vec) = tt[vec].
- IDLE:
  - start=1 at an edge: go to LOAD, capture stop_on_mismatch.
  - Result outputs are held from the previous sweep.
  - start=0: remain in IDLE.
- LOAD (1 cycle):
  - Capture tt_a and tt_b into internal registers; later changes to the inputs do not affect the sweep.
  - Clear vec, mismatch_count, ones_a and first_mismatch; set a found flag to 0.
  - Go to SWEEP.
- SWEEP (one vector per cycle). At each edge:
  - ones_a increments if ta[vec]=1.
  - If ta[vec]!=tb[vec]: mismatch_count increments; if found=0, first_mismatch<=vec and found<=1.
  - Exit to DONE when vec==TT_W-1, or when a mismatch is detected and stop_on_mismatch was captured as 1. Otherwise vec increments.
  - vec never wraps inside a sweep.
- DONE (1 cycle):
  - done=1; equal = (mismatch_count==0).
  - Go to IDLE; start is not sampled in DONE.
- Latency:
  - With start sampled at edge 0, a full sweep asserts done in the cycle after edge TT_W+1 (edge 17 for N=4).
  - An early stop at vector k asserts done after edge k+2.
- start while busy or in DONE is ignored and not queued.
- Counter widths: mismatch_count and ones_a are N+1 bits, so all TT_W mismatches (e.g. 16 for N=4) are representable without overflow.
- In stop mode mismatch_count is at most 1. ones_a covers only the vectors evaluated.
- equal is valid from done until the next start; it clears to 0 in LOAD.

Decomposition:
- Shared package func_pkg:
  - State enum: IDLE, LOAD, SWEEP, DONE.
  - Function tt_popcount, used by benches as the reference model.
- One sub-module, func_lut: a TT_W:1 mux, parameter N, ports tt and vec, output f. It is instantiated twice, for A and B.

Test Plan:
- N=4, tt_a=tt_b=16'hFFFE (4-input OR), stop=0 -> done pulse after edge 17; equal=1, mismatch_count=0, first_mismatch=0, ones_a=15, busy high for exactly 17 cycles.
- tt_a=16'hFFFE, tt_b=16'h7FFE, stop=0 -> equal=0, first_mismatch=15, mismatch_count=1, ones_a=15.
- tt_a=16'hAAAA, tt_b=16'h5555, stop=0 -> mismatch_count=16, first_mismatch=0, ones_a=8. Repeat with stop=1 -> done after edge 2, mismatch_count=1, ones_a=0.
- Start a sweep, change tt_b and pulse start during SWEEP -> results match the originally loaded tables; exactly one done pulse.
- Assert reset at vector 7 of a sweep, release, then issue start with tt_a=tt_b=16'h0000 -> all outputs 0 during reset, no done from the aborted sweep; new sweep gives equal=1, ones_a=0.
- N=1 and N=10 builds: tt_a=all ones, tt_b=all ones except bit TT_W-1 -> first_mismatch=TT_W-1, mismatch_count=1, ones_a=TT_W.
